// File: rtl/locked_stream_arbiter_if.sv
// Bundled input/output stream signals for locked_stream_arbiter.
// The master modport is the arbiter's view; slave is the sources/sink side.
interface locked_stream_arbiter_if #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [WIDTH-1:0]            in_valid;
  logic [WIDTH-1:0]            in_ready;
  logic [WIDTH*DATA_WIDTH-1:0] in_data;
  logic [WIDTH-1:0]            in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        out_last;
  logic [WIDTH-1:0]            out_sel;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/locked_stream_arbiter.sv
// Packet-locked priority arbiter: merges WIDTH valid/ready streams into one registered
// output stream, keeping the grant on one source until its last beat is accepted.
module locked_stream_arbiter #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  locked_stream_arbiter_if.master bus,
  output logic                   busy
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      lock_grant_q, lock_grant_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic [WIDTH-1:0]      out_sel_q;

  logic                  can_accept;
  logic [WIDTH-1:0]      cand;
  logic [WIDTH-1:0]      neg_valid;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  assign can_accept = !out_valid_q || bus.out_ready;
  // Two's-complement isolate-lowest-set-bit picks the lowest requesting index.
  assign neg_valid  = ~bus.in_valid + WIDTH'(1);
  assign cand       = (state_q == StIdle) ? (bus.in_valid & neg_valid)
                                          : (lock_grant_q & bus.in_valid);
  assign bus.in_ready = (rst || !can_accept) ? '0 : cand;
  assign accept       = |(bus.in_valid & bus.in_ready);

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (cand[i]) begin
        sel_data = sel_data | bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    sel_last = |(cand & bus.in_last);
  end

  always_comb begin
    state_d      = state_q;
    lock_grant_d = lock_grant_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !sel_last) begin
          state_d      = StLocked;
          lock_grant_d = cand;
        end
      end
      StLocked: begin
        if (accept && sel_last) begin
          state_d      = StIdle;
          lock_grant_d = '0;
        end
      end
      default: begin
        state_d      = StIdle;
        lock_grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      lock_grant_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      lock_grant_q <= lock_grant_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_last_q  <= sel_last;
        out_sel_q   <= cand;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
  assign busy          = (state_q == StLocked);

endmodule

// File: tb/tb_locked_stream_arbiter.sv
// Directed bench for locked_stream_arbiter: expected output beats go into a scoreboard
// queue and a separate monitor pops and compares each beat taken by the sink.
module tb_locked_stream_arbiter;
  localparam int unsigned W  = 4;
  localparam int unsigned DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [W-1:0]  sel;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  busy;
  int    total = 0;
  int    bad   = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  locked_stream_arbiter_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();

  locked_stream_arbiter #(.WIDTH(W), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic exp_beat(input logic [DW-1:0] d, input logic l, input logic [W-1:0] s);
    beat_t b;
    b.data = d;
    b.last = l;
    b.sel  = s;
    sb.push_back(b);
  endtask

  task automatic set_in(input int i, input logic [DW-1:0] d, input logic l);
    bus.in_data[i*DW +: DW] = d;
    bus.in_last[i]          = l;
  endtask

  // Inputs change 1 time unit after the rising edge; checks are made before the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a beat seen valid&ready at the falling edge transfers on the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", bus.out_data, '0);
        total++;
        bad++;
        $display("FAIL unexpected_beat: got data %h with empty scoreboard", bus.out_data);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("sb_data", bus.out_data, e.data);
        chk("sb_last", DW'(bus.out_last), DW'(e.last));
        chk("sb_sel", DW'(bus.out_sel), DW'(e.sel));
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_data   = '0;
    bus.in_last   = 4'hF;
    bus.out_ready = 1'b1;

    // Reset held 3 cycles with every input requesting
    repeat (3) cyc();
    chk("rst_in_ready", DW'(bus.in_ready), 0);
    chk("rst_out_valid", DW'(bus.out_valid), 0);
    chk("rst_out_sel", DW'(bus.out_sel), 0);
    chk("rst_busy", DW'(busy), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", DW'(bus.in_ready), 32'b0001);
    bus.in_valid = '0;
    cyc();

    // Priority: inputs 1 and 3 request single-beat packets
    set_in(1, 32'h11, 1'b1);
    set_in(3, 32'h33, 1'b1);
    bus.in_valid = 4'b1010;
    exp_beat(32'h11, 1'b1, 4'b0010);
    exp_beat(32'h33, 1'b1, 4'b1000);
    #1 chk("prio_ready1", DW'(bus.in_ready), 32'b0010);
    cyc();
    bus.in_valid = 4'b1000;
    #1;
    chk("prio_out1_valid", DW'(bus.out_valid), 1);
    chk("prio_out1_sel", DW'(bus.out_sel), 32'b0010);
    chk("prio_ready3", DW'(bus.in_ready), 32'b1000);
    cyc();
    bus.in_valid = '0;
    chk("prio_out3_sel", DW'(bus.out_sel), 32'b1000);
    cyc();
    cyc();

    // Locking: input 2 sends 3 beats while input 0 waits
    set_in(2, 32'hA0, 1'b0);
    bus.in_valid = 4'b0100;
    exp_beat(32'hA0, 1'b0, 4'b0100);
    exp_beat(32'hA1, 1'b0, 4'b0100);
    exp_beat(32'hA2, 1'b1, 4'b0100);
    exp_beat(32'h05, 1'b1, 4'b0001);
    #1;
    chk("lock_ready_a0", DW'(bus.in_ready), 32'b0100);
    chk("lock_busy0", DW'(busy), 0);
    cyc();
    set_in(2, 32'hA1, 1'b0);
    set_in(0, 32'h05, 1'b1);
    bus.in_valid = 4'b0101;
    #1;
    chk("lock_busy1", DW'(busy), 1);
    chk("lock_ready_a1", DW'(bus.in_ready), 32'b0100);
    cyc();
    set_in(2, 32'hA2, 1'b1);
    #1;
    chk("lock_busy2", DW'(busy), 1);
    chk("lock_ready_a2", DW'(bus.in_ready), 32'b0100);
    cyc();
    bus.in_valid = 4'b0001;
    #1;
    chk("lock_busy_end", DW'(busy), 0);
    chk("lock_ready_in0", DW'(bus.in_ready), 32'b0001);
    cyc();
    bus.in_valid = '0;
    cyc();
    cyc();

    // Backpressure: hold a beat for 4 cycles, then replace it with no bubble
    set_in(1, 32'h77, 1'b1);
    bus.in_valid = 4'b0010;
    exp_beat(32'h77, 1'b1, 4'b0010);
    exp_beat(32'h78, 1'b1, 4'b0010);
    cyc();
    bus.out_ready = 1'b0;
    set_in(1, 32'h78, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_valid", DW'(bus.out_valid), 1);
      chk("bp_data", bus.out_data, 32'h77);
      chk("bp_last", DW'(bus.out_last), 1);
      chk("bp_sel", DW'(bus.out_sel), 32'b0010);
      chk("bp_ready", DW'(bus.in_ready), 0);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", DW'(bus.in_ready), 32'b0010);
    cyc();
    bus.in_valid = '0;
    chk("bp_cont_valid", DW'(bus.out_valid), 1);
    chk("bp_cont_data", bus.out_data, 32'h78);
    cyc();
    cyc();

    // Source stall: locked input 1 pauses for 2 cycles while input 0 requests
    set_in(1, 32'hB0, 1'b0);
    bus.in_valid = 4'b0010;
    exp_beat(32'hB0, 1'b0, 4'b0010);
    exp_beat(32'hB1, 1'b0, 4'b0010);
    exp_beat(32'hB2, 1'b1, 4'b0010);
    exp_beat(32'h0C, 1'b1, 4'b0001);
    cyc();
    set_in(0, 32'h0C, 1'b1);
    bus.in_valid = 4'b0001;
    #1;
    chk("stall_ready0", DW'(bus.in_ready), 0);
    chk("stall_busy0", DW'(busy), 1);
    chk("stall_valid0", DW'(bus.out_valid), 1);
    cyc();
    chk("stall_ready1", DW'(bus.in_ready), 0);
    chk("stall_busy1", DW'(busy), 1);
    chk("stall_drained", DW'(bus.out_valid), 0);
    cyc();
    set_in(1, 32'hB1, 1'b0);
    bus.in_valid = 4'b0011;
    #1 chk("stall_resume", DW'(bus.in_ready), 32'b0010);
    cyc();
    set_in(1, 32'hB2, 1'b1);
    #1 chk("stall_busy2", DW'(busy), 1);
    cyc();
    bus.in_valid = 4'b0001;
    #1;
    chk("stall_busy_end", DW'(busy), 0);
    chk("stall_ready_in0", DW'(bus.in_ready), 32'b0001);
    cyc();
    bus.in_valid = '0;
    cyc();
    cyc();

    // Reset mid-packet: input 3 beat is held under backpressure, then discarded
    bus.out_ready = 1'b0;
    set_in(3, 32'hD0, 1'b0);
    bus.in_valid = 4'b1000;
    cyc();
    set_in(3, 32'hD1, 1'b0);
    set_in(0, 32'hE0, 1'b1);
    bus.in_valid = 4'b1001;
    #1;
    chk("mid_busy", DW'(busy), 1);
    chk("mid_valid", DW'(bus.out_valid), 1);
    rst = 1'b1;
    #1 chk("mid_rst_ready", DW'(bus.in_ready), 0);
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    exp_beat(32'hE0, 1'b1, 4'b0001);
    #1;
    chk("mid_busy_after", DW'(busy), 0);
    chk("mid_valid_after", DW'(bus.out_valid), 0);
    chk("mid_regrant", DW'(bus.in_ready), 32'b0001);
    cyc();
    bus.in_valid = '0;
    chk("mid_out_sel", DW'(bus.out_sel), 32'b0001);
    cyc();
    cyc();
    cyc();

    chk("sb_empty", DW'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound on the whole run
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got t=%0t want <20000", $time);
    $fatal(1);
  end
endmodule

// File: doc/locked_stream_arbiter.md
Name: locked_stream_arbiter

Overview:
- Multiplexes WIDTH valid/ready packet streams onto one output stream, granting one whole packet at a time.
- In the idle state the grant is the lowest-index requesting input. This is the same less-significant-bit-first rule as the priority arbiter, applied to the in_valid vector.
- The grant is locked from the first beat of a packet until its in_last beat is accepted.
- Output is a one-entry registered stage. The block sits between multiple DMA/bus masters and a shared single-port sink.

Parameters:
- WIDTH, 4: number of input streams (>=1).
- DATA_WIDTH, 32: payload bits per beat.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, WIDTH: per-input beat valid.
- in_ready, output, WIDTH: per-input beat accepted.
- in_data, input, WIDTH*DATA_WIDTH: packed payloads; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last, input, WIDTH: per-input end-of-packet flag.
- out_valid, output, 1: output register holds a beat.
- out_ready, input, 1: sink accepts the output beat.
- out_data, output, DATA_WIDTH: registered payload.
- out_last, output, 1: registered end-of-packet flag.
- out_sel, output, WIDTH: one-hot index of the source of the current output beat.
- busy, output, 1: high while in LOCKED.

Behaviour:
- Reset (rst high at a clock edge):
  - state <= IDLE, lock_grant <= 0.
  - out_valid, out_data, out_last and out_sel <= 0.
  - While rst is high, in_ready is forced to all-zero.
- Handshakes:
  - A transfer on a port occurs when valid & ready are both high at a rising edge.
  - in_valid and in_data/in_last of a source must remain stable until accepted.
  - out_* are held stable while out_valid & !out_ready.
- Combinational signals:
  - can_accept = !out_valid | out_ready.
  - cand = (state==IDLE) ? (in_valid & -in_valid) : (lock_grant & in_valid).
  - Arithmetic for cand is WIDTH bits, two's complement, with wrap.
  - in_ready = can_accept ? cand : 0. At most one bit is set.
  - There is a combinational path from out_ready and from in_valid to in_ready. No path from in_data to any output.
- Accept event: accept = |(in_valid & in_ready). The selected input is the one-hot cand.
- On accept, at the clock edge:
  - out_valid <= 1.
  - out_data <= selected in_data; out_last <= selected in_last; out_sel <= cand.
- On !accept & out_ready: out_valid <= 0. out_data, out_last and out_sel keep their values.
- Latency: exactly 1 cycle from input acceptance to out_valid.
- Throughput: 1 beat/cycle sustained when out_ready is held high.
- State machine, two states:
  - IDLE & accept & !last -> LOCKED, lock_grant <= cand.
  - IDLE & accept & last -> IDLE. Single-beat packets never lock.
  - LOCKED & accept & last -> IDLE, lock_grant <= 0.
  - LOCKED & (!accept | !last) -> LOCKED.
  - In LOCKED, other inputs see in_ready=0 regardless of their valid, including lower-index inputs.
  - If the locked source drops in_valid mid-packet, no beat is taken and the lock holds. There is no timeout.
- busy = (state==LOCKED), a registered-state output.
- Back-to-back packets: the cycle the last beat is accepted, the next edge enters IDLE. The next grant is decided by priority in the following cycle with no bubble beyond that cycle's arbitration. The same input may be regranted immediately if it still requests and has the lowest index.
- Simultaneous out_ready and new accept in the same cycle: the output register is replaced with no bubble.
- Reset mid-packet: lock and output beat are discarded; the state after reset is IDLE.
- WIDTH=1: degenerates to a registered pipeline stage with packet tracking. Still legal.

Test Plan:
- Reset: hold rst 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_sel=0, busy=0. In the first cycle after release, in_ready=4'b0001.
- Priority: in_valid=4'b1010, single-beat packets, in_last=1, out_ready=1 -> input 1 is granted. Then, once input 1 deasserts, input 3 is granted. out_sel sequence is 0010, 1000, each beat 1 cycle after acceptance.
- Locking: input 2 sends 3 beats (data 0xA0, 0xA1, 0xA2, last on the third). Input 0 raises valid after beat 1 -> in_ready[0] stays 0 until 0xA2 is accepted, and busy=1 for 2 cycles. Input 0 is granted the next cycle.
- Backpressure: out_ready=0 for 4 cycles with a beat held -> out_data/out_last/out_sel stay constant and in_ready=0. Raising out_ready accepts a new beat in the same cycle, giving continuous out_valid.
- Source stall: locked input 1 drops in_valid for 2 cycles mid-packet while input 0 is valid -> no beat is accepted from input 0, out_valid falls once drained, and busy stays 1.
- Reset mid-packet: assert rst after beat 1 of a 4-beat packet from input 3 -> busy=0 and out_valid=0 after reset. Input 0, now requesting, is granted first.
